// File: rtl/arb_pkg.sv
// Shared types and width helper for the data-memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request bit above i_last, wrapping.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic             w_hi_found;
  logic             w_lo_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Descending scan so the lowest set bit in each region is the one kept.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (i > int'(i_last)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign o_grant_valid = w_hi_found | w_lo_found;
  assign o_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_REQ requesters.
//   state | meaning
//   IDLE  | waiting for a request; winner latched on exit
//   ISSUE | strobe driven; writes acknowledged here
//   RDATA | memory data returned with the read acknowledge
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  i_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  i_wdata,
  output logic [N_REQ-1:0]              o_ack,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_busy,
  output logic                          o_mem_read,
  output logic                          o_mem_write,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_grant_valid;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [N_REQ-1:0]  w_idx_onehot;
  logic              w_ack_en;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req         (i_req),
    .i_last        (r_last),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_we ? IDLE : RDATA;
      RDATA:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(N_REQ - 1);
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_grant_valid) begin
        r_last  <= w_grant_idx;
        r_idx   <= w_grant_idx;
        r_we    <= i_we[w_grant_idx];
        r_addr  <= i_addr[w_grant_idx];
        r_wdata <= i_wdata[w_grant_idx];
      end
      if (r_state == RDATA) r_rdata <= i_mem_rdata;
    end
  end

  assign w_idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;

  // Reset in the acknowledge cycle aborts the transaction, so it masks ack.
  assign w_ack_en = ~i_reset & (((r_state == ISSUE) & r_we) | (r_state == RDATA));

  assign o_ack       = w_ack_en ? w_idx_onehot : '0;
  assign o_busy      = (r_state != IDLE);
  assign o_mem_write = (r_state == ISSUE) & r_we;
  assign o_mem_read  = (r_state == ISSUE) & ~r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  // Memory data arrives in RDATA; the registered copy holds it afterwards.
  assign o_rdata     = (r_state == RDATA) ? i_mem_rdata : r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       we;
  logic [3:0][15:0] addr;
  logic [3:0][15:0] wdata;
  logic [3:0]       ack;
  logic [15:0]      rdata;
  logic             busy;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Read data is addr + 0x1224, valid only in the cycle after the strobe.
  always @(posedge clk) mem_rdata <= mem_read ? (mem_addr + 16'h1224) : 16'hDEAD;

  mem_arbiter #(
    .N_REQ  (4),
    .ADDR_W (16),
    .DATA_W (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy), 0);
    check("rst_ack",   32'(ack), 0);
    check("rst_rd",    32'(mem_read), 0);
    check("rst_wr",    32'(mem_write), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;

    // single write from requester 2
    addr[2] = 16'h0040; wdata[2] = 16'hBEEF; we = 4'b0100; req = 4'b0100;
    @(negedge clk);
    check("wr_strobe", 32'(mem_write), 1);
    check("wr_rd",     32'(mem_read), 0);
    check("wr_addr",   32'(mem_addr), 'h0040);
    check("wr_wdata",  32'(mem_wdata), 'hBEEF);
    check("wr_ack",    32'(ack), 'b0100);
    check("wr_busy",   32'(busy), 1);
    req = '0;
    @(negedge clk);
    check("wr_done_busy", 32'(busy), 0);
    check("wr_done_ack",  32'(ack), 0);
    check("wr_done_wr",   32'(mem_write), 0);

    // single read from requester 0
    we = '0; addr[0] = 16'h0010; req = 4'b0001;
    @(negedge clk);
    check("rd_strobe", 32'(mem_read), 1);
    check("rd_wr",     32'(mem_write), 0);
    check("rd_addr",   32'(mem_addr), 'h0010);
    check("rd_ack1",   32'(ack), 0);
    check("rd_busy",   32'(busy), 1);
    @(negedge clk);
    check("rd_ack2",   32'(ack), 'b0001);
    check("rd_data",   32'(rdata), 'h1234);
    check("rd_rd2",    32'(mem_read), 0);
    check("rd_wr2",    32'(mem_write), 0);
    req = '0;
    @(negedge clk);
    check("rd_done_busy", 32'(busy), 0);

    // round robin from reset, all four writing
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 16'(32'h0100 + i);
      wdata[i] = 16'(32'hA000 + i);
    end
    we = 4'hF; req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_ack",   32'(ack), 32'(1) << (k % 4));
      check("rr_addr",  32'(mem_addr), 32'h0100 + (k % 4));
      check("rr_wdata", 32'(mem_wdata), 32'hA000 + (k % 4));
      check("rr_wr",    32'(mem_write), 1);
      if (k == 4) req = '0;
      @(negedge clk);
      check("rr_gap_ack",  32'(ack), 0);
      check("rr_gap_busy", 32'(busy), 0);
    end

    // fairness: bring last to 1, then 1 and 3 compete
    req = 4'b0010;
    @(negedge clk);
    check("fs_pre_ack", 32'(ack), 'b0010);
    req = '0;
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    check("fs_ack3",  32'(ack), 'b1000);
    check("fs_addr3", 32'(mem_addr), 'h0103);
    req = 4'b0010;
    @(negedge clk);
    check("fs_idle1", 32'(busy), 0);
    @(negedge clk);
    check("fs_ack1",  32'(ack), 'b0010);
    req = 4'b0110;
    @(negedge clk);
    check("fs_idle2", 32'(busy), 0);
    @(negedge clk);
    check("fs_ack2",  32'(ack), 'b0100);
    check("fs_addr2", 32'(mem_addr), 'h0102);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("fs_ack1b", 32'(ack), 'b0010);
    req = '0;
    @(negedge clk);
    check("fs_idle3", 32'(busy), 0);

    // reset in the RDATA cycle of a read by requester 1
    we = '0; req = 4'b0010;
    @(negedge clk);
    check("rr_rd_strobe", 32'(mem_read), 1);
    check("rr_rd_addr",   32'(mem_addr), 'h0101);
    @(posedge clk);
    #1;
    reset = 1'b1; req = 4'b1001; we = 4'b0001;
    @(negedge clk);
    check("rst_rdata_ack", 32'(ack), 0);
    check("rst_rdata_wr",  32'(mem_write), 0);
    @(negedge clk);
    check("rst_after_busy", 32'(busy), 0);
    check("rst_after_rd",   32'(mem_read), 0);
    check("rst_after_wr",   32'(mem_write), 0);
    check("rst_after_ack",  32'(ack), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_prio_ack",   32'(ack), 'b0001);
    check("rst_prio_wr",    32'(mem_write), 1);
    check("rst_prio_addr",  32'(mem_addr), 'h0100);
    check("rst_prio_wdata", 32'(mem_wdata), 'hA000);
    req = '0;
    @(negedge clk);
    check("rst_prio_idle", 32'(busy), 0);

    // early request drop during ISSUE of a read by requester 2
    we = '0; addr[2] = 16'h0042; req = 4'b0100;
    @(negedge clk);
    check("ed_strobe", 32'(mem_read), 1);
    check("ed_addr",   32'(mem_addr), 'h0042);
    req = '0;
    @(negedge clk);
    check("ed_ack",   32'(ack), 'b0100);
    check("ed_rdata", 32'(rdata), 'h1266);
    @(negedge clk);
    check("ed_idle1", 32'(busy), 0);
    @(negedge clk);
    check("ed_idle2", 32'(busy), 0);
    check("ed_rd",    32'(mem_read), 0);
    check("ed_ack0",  32'(ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
